kv_way_alloc_ctrl: RTL
======================

// Module: kv_way_alloc_ctrl
// PURPOSE
//  Per-set way allocator for the set-associative caches; sequences refill victim selection.
//  Keeps a valid bit and a tree-PLRU state per way/set, and returns a one-hot victim per request.
//  An invalid way is chosen first: the lowest-index invalid way (killmask rule). Otherwise the PLRU way.
//  Sits between the miss handler (requester) and the tag/data array write enables.
// PARAMETERS
//  WAY_NUM  4   ways per set; power of two, >=2
//  SET_NUM  64  sets; power of two, >=2
//  SET_W    $clog2(SET_NUM)  derived (localparam); set index width
// PORTS
//  i_clk          in   1        clock, rising edge
//  i_rst_n        in   1        async active-low reset
//  i_req_valid    in   1        allocation request
//  o_req_ready    out  1        request accept; high only in IDLE
//  i_req_set      in   SET_W    set index of request
//  o_rsp_valid    out  1        victim response valid
//  i_rsp_ready    in   1        requester accepts victim -> commit
//  o_rsp_way      out  WAY_NUM  one-hot victim way
//  o_rsp_evict    out  1        1 = victim was valid (writeback/evict needed)
//  i_touch_valid  in   1        hit-access PLRU update
//  i_touch_set    in   SET_W    set of hit
//  i_touch_way    in   WAY_NUM  one-hot hit way
//  i_inv_valid    in   1        invalidate one way
//  i_inv_set      in   SET_W    set to invalidate
//  i_inv_way      in   WAY_NUM  one-hot way to invalidate
//  i_flush        in   1        clear all valid bits and all PLRU state
//  o_evict_cnt    out  32       (KV_WAY_ALLOC_PERF_EN only) eviction count
// BEHAVIOUR
//  - Reset: FSM=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_way=0, o_rsp_evict=0,
//    all valid bits=0, all PLRU bits=0, o_evict_cnt=0.
//  - FSM: IDLE -(req_valid&req_ready)-> LOOKUP -> RESP -(rsp_valid&rsp_ready)-> IDLE.
//    Accept at cycle T. LOOKUP (T+1) reads the set and registers the victim. o_rsp_valid=1 from T+2.
//  - RESP: o_rsp_way/o_rsp_evict stay stable until accepted, even if state changes meanwhile.
//  - Commit (accept cycle): set valid[set][way]; PLRU update as an access to way; then IDLE.
//    Next request can be accepted the cycle after the commit.
//  - PLRU: WAY_NUM-1 bits per set; node 0 = root; children of node n = 2n+1, 2n+2.
//    Node bit 0 -> victim in lower-index half; 1 -> upper half.
//    An access sets each node on its path to point away from the accessed way.
//  - Touch: PLRU access update in the same cycle, in any FSM state. A zero way is ignored.
//    Non-one-hot way = undefined.
//  - Invalidate: clears the valid bit in the same cycle; PLRU unchanged.
//  - Same cycle, same set:
//    - commit and touch: touch is applied first, commit's PLRU update last (commit wins).
//    - commit and inv of the committed way: valid ends at 1 (commit wins).
//    - touch/inv during LOOKUP: the LOOKUP read sees pre-update state.
//  - i_flush: takes priority over all else; any state -> IDLE next cycle.
//    o_rsp_valid drops next cycle; the in-flight request is dropped, not committed.
//    Valid and PLRU are cleared; o_evict_cnt is not cleared.
//  - Request set index is captured at accept; i_req_set is ignored after that.
//  - Async reset mid-operation: immediate return to reset values; no commit.
// CONFIGURATION
//  `KV_WAY_ALLOC_PERF_EN defined:
//    o_evict_cnt present; +1 on each commit with o_rsp_evict=1; saturates at 32'hFFFF_FFFF.
//  Not defined: port and counter absent; no other behaviour change.
// TESTING
//  1 Reset; 4 allocs to set 3 -> ways 0001,0010,0100,1000; evict=0; rsp_valid 2 cycles after accept.
//  2 Continue: 5th alloc set 3 -> 0001, evict=1.
//    Then touch set3 way0001; alloc -> 0100, evict=1.
//  3 inv set3 way 0010; alloc set3 -> 0010, evict=0; set 5 untouched -> 0001, evict=0.
//  4 Hold rsp_ready=0 for 5 cycles while touching same set -> rsp_way/evict stable;
//    touch+commit same cycle -> PLRU reflects commit way.
//  5 i_flush in RESP -> rsp_valid=0 next cycle, no commit; next alloc any set -> 0001, evict=0.
//  6 PERF_EN: 3 evicting commits -> o_evict_cnt=3; flush -> still 3;
//    async reset mid-LOOKUP -> 0, ready=1.

Source files
------------

// File: rtl/kv_way_alloc_ctrl.sv
// Per-set way allocator: valid bits plus tree-PLRU per set, one-hot victim per request.
// Optional eviction counter (o_evict_cnt) is built when KV_WAY_ALLOC_PERF_EN is defined.
module kv_way_alloc_ctrl #(
  parameter int WAY_NUM = 4,
  parameter int SET_NUM = 64,
  localparam int SET_W = $clog2(SET_NUM)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [SET_W-1:0]   i_req_set,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [WAY_NUM-1:0] o_rsp_way,
  output logic               o_rsp_evict,
  input  logic               i_touch_valid,
  input  logic [SET_W-1:0]   i_touch_set,
  input  logic [WAY_NUM-1:0] i_touch_way,
  input  logic               i_inv_valid,
  input  logic [SET_W-1:0]   i_inv_set,
  input  logic [WAY_NUM-1:0] i_inv_way,
  input  logic               i_flush
`ifdef KV_WAY_ALLOC_PERF_EN
  ,
  output logic [31:0]        o_evict_cnt
`endif
);

  localparam int LVL   = $clog2(WAY_NUM);
  localparam int NODES = WAY_NUM - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Handshakes: a request transfers when i_req_valid & o_req_ready; a victim
  // transfers (and commits) when o_rsp_valid & i_rsp_ready. i_flush overrides both.

  logic [1:0]         state_q;
  logic [SET_W-1:0]   set_q;
  logic [WAY_NUM-1:0] valid_q [SET_NUM];
  logic [NODES-1:0]   plru_q  [SET_NUM];
  logic [WAY_NUM-1:0] rsp_way_q;
  logic               rsp_evict_q;

  function automatic int oh2idx(input logic [WAY_NUM-1:0] oh);
    int idx;
    idx = 0;
    for (int w = 0; w < WAY_NUM; w++)
      if (oh[w]) idx = w;
    return idx;
  endfunction

  // Walk from the root: each node bit picks the half holding the victim.
  function automatic logic [WAY_NUM-1:0] plru_victim(input logic [NODES-1:0] t);
    int node;
    logic [WAY_NUM-1:0] v;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      int b;
      b = 0;
      for (int n = 0; n < NODES; n++)
        if (n == node) b = int'(t[n]);
      node = 2 * node + 1 + b;
    end
    v = '0;
    for (int w = 0; w < WAY_NUM; w++)
      if (w == node - NODES) v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [NODES-1:0] plru_update(input logic [NODES-1:0] t, input int idx);
    int node;
    int d;
    logic [NODES-1:0] r;
    r = t;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      d = (idx >> (LVL - 1 - l)) & 1;
      for (int n = 0; n < NODES; n++)
        if (n == node) r[n] = (d == 0);
      node = 2 * node + 1 + d;
    end
    return r;
  endfunction

  logic               accept;
  logic               commit;
  logic               touch_en;
  logic [NODES-1:0]   touch_row;
  logic [NODES-1:0]   commit_plru;
  logic [WAY_NUM-1:0] inv_row;
  logic [WAY_NUM-1:0] commit_valid;
  logic [WAY_NUM-1:0] lk_valid;
  logic [WAY_NUM-1:0] lk_free;
  logic [WAY_NUM-1:0] lk_way;

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_way   = rsp_way_q;
  assign o_rsp_evict = rsp_evict_q;

  assign accept   = i_req_valid & o_req_ready & ~i_flush;
  assign commit   = o_rsp_valid & i_rsp_ready & ~i_flush;
  assign touch_en = i_touch_valid & (|i_touch_way);

  // Commit is layered on top of a same-set touch/invalidate so that it wins.
  always_comb begin
    touch_row    = plru_update(plru_q[i_touch_set], oh2idx(i_touch_way));
    commit_plru  = (touch_en && i_touch_set == set_q) ? touch_row : plru_q[set_q];
    commit_plru  = plru_update(commit_plru, oh2idx(rsp_way_q));
    inv_row      = valid_q[i_inv_set] & ~i_inv_way;
    commit_valid = (i_inv_valid && i_inv_set == set_q) ? inv_row : valid_q[set_q];
    commit_valid = commit_valid | rsp_way_q;
  end

  always_comb begin
    lk_valid = valid_q[set_q];
    lk_free  = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--)
      if (!lk_valid[w]) lk_free = WAY_NUM'(1) << w;
    lk_way = (&lk_valid) ? plru_victim(plru_q[set_q]) : lk_free;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      set_q       <= '0;
      rsp_way_q   <= '0;
      rsp_evict_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          state_q <= ST_LOOKUP;
          set_q   <= i_req_set;
        end
        ST_LOOKUP: begin
          state_q     <= ST_RESP;
          rsp_way_q   <= lk_way;
          rsp_evict_q <= &lk_valid;
        end
        ST_RESP: if (commit) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (i_flush) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (touch_en)    plru_q[i_touch_set] <= touch_row;
      if (i_inv_valid) valid_q[i_inv_set]  <= inv_row;
      if (commit) begin
        plru_q[set_q]  <= commit_plru;
        valid_q[set_q] <= commit_valid;
      end
    end
  end

`ifdef KV_WAY_ALLOC_PERF_EN
  logic [31:0] evict_cnt_q;
  assign o_evict_cnt = evict_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      evict_cnt_q <= '0;
    else if (commit && rsp_evict_q && evict_cnt_q != 32'hFFFF_FFFF)
      evict_cnt_q <= evict_cnt_q + 32'd1;
  end
`endif

endmodule
